framer_trigger_sched: RTL and testbench
=======================================

// Module: framer_trigger_sched
// PURPOSE
//  Generates the per-sample trigger AXI stream that feeds the trigger port of periodic_framer.
//  Emits one beat per sample. tlast marks a trigger sample: after an initial delay, one every PERIOD beats.
//  Trigger count is programmable; 0 = continuous. Configured over the settings bus or by an external start strobe.
//  Sits beside the framer in the RFNoC block and sequences when each framed burst begins.
// PARAMETERS
//  SR_TRIG_PERIOD  5  settings addr: [15:0] beats between triggers (0 treated as 1)
//  SR_TRIG_DELAY   6  settings addr: [15:0] beats from start to first trigger
//  SR_TRIG_COUNT   7  settings addr: [15:0] triggers per run, 0 = continuous
//  SR_TRIG_CTRL    8  settings addr: bit0 start, bit1 stop (write-strobe commands, not stored)
// PORTS
//  clk             in   1   clock
//  reset_n         in   1   asynchronous reset, active low
//  clear           in   1   synchronous clear: same effect as reset on state/counters, config regs kept
//  set_stb         in   1   settings strobe
//  set_addr        in   8   settings address
//  set_data        in   32  settings data
//  ext_start       in   1   1-cycle start strobe (e.g. timed command)
//  trigger_tdata   out  16  trigger index of current run (0-based)
//  trigger_tlast   out  1   1 = this beat is a trigger sample
//  trigger_tvalid  out  1   beat valid
//  trigger_tready  in   1   downstream accepts beat
//  busy            out  1   1 in ST_DELAY/ST_RUN
//  done            out  1   1-cycle pulse when COUNT triggers completed
// BEHAVIOUR
//  Reset (reset_n=0, async): state=ST_IDLE, all counters and config regs 0; tdata=0, tlast=0, tvalid=1, busy=0, done=0.
//  Handshake: beat = tvalid&tready. tvalid is 1 in every state, so the framer never stalls the sample stream.
//   tdata/tlast change only on a beat; both hold while tready=0.
//  States:
//   ST_IDLE: tlast=0, tdata=0. Start (SR_TRIG_CTRL bit0 or ext_start) -> ST_DELAY, beat_cnt=0, trig_idx=0.
//   ST_DELAY: tlast=0. On each beat beat_cnt++. The beat on which beat_cnt==DELAY is itself the first trigger:
//    tlast=1 presented when beat_cnt==DELAY. On that beat -> ST_RUN, beat_cnt=1, trig_idx++.
//    DELAY=0: the first beat after start carries tlast=1.
//   ST_RUN: tlast=1 when beat_cnt>=PERIOD_eff, where PERIOD_eff=max(PERIOD,1).
//    Each beat: beat_cnt++, or beat_cnt=1 on a trigger beat.
//    On a trigger beat: trig_idx++. If COUNT!=0 and trig_idx+1==COUNT -> ST_IDLE and pulse done next cycle.
//  tdata = trig_idx (wraps 16 bit at 0xFFFF->0 in continuous mode, no other effect).
//  Latency: start strobe at cycle t -> ST_DELAY at t+1; the first tlast is on the (DELAY+1)th beat after t.
//  Stop (SR_TRIG_CTRL bit1): latched as stop_pend.
//   If the presented beat has tlast=0 -> ST_IDLE next cycle.
//   If tlast=1 is presented (possibly stalled) -> hold it, go ST_IDLE after that beat. No done pulse.
//  Start and stop in the same write: stop wins. Start while busy: ignored.
//   ext_start and a settings start in the same cycle count as one start.
//  PERIOD/DELAY/COUNT writes while busy take effect at the next comparison. No restart occurs.
//   If the counter already exceeds the new PERIOD, the next beat triggers (>= compare).
//  COUNT=1: one trigger, then ST_IDLE. COUNT=0: runs until stop/clear.
//  clear mid-run: ST_IDLE next cycle, tlast=0, done not pulsed, config regs retained.
//  reset_n asserted mid-run: immediate return to reset values, including config regs.
//  Widths: beat_cnt and trig_idx 16 bit. beat_cnt saturates at 0xFFFF (no wrap).
// TESTING
//  1 PERIOD=4, DELAY=2, COUNT=3, start, tready=1 -> tlast on beats 3,7,11; tdata 0,1,2; done 1 cycle after beat 11; busy low after.
//  2 Same config, tready toggled 1/0 pseudo-random -> identical tlast beat positions; tdata/tlast stable while tready=0.
//  3 COUNT=0, PERIOD=1, DELAY=0 -> tlast on every beat; tdata 0..0xFFFF then wraps to 0; no done.
//  4 Stop written while a tlast=1 beat is stalled by tready=0 -> that beat completes with tlast=1, then idle; no done.
//  5 Start+stop in one write -> stays ST_IDLE. Start while busy -> sequence unchanged.
//  6 clear at beat 5 of a run -> idle next cycle, tlast=0; new start reuses PERIOD/DELAY/COUNT. reset_n pulse -> all outputs at reset values.

Source files
------------

// File: rtl/framer_trigger_sched_if.sv
// Settings bus and trigger AXI stream shared between the trigger scheduler and its host.
// master: drives settings writes and consumes the trigger stream.
// slave : the scheduler itself.
interface framer_trigger_sched_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [15:0] trigger_tdata;
    logic        trigger_tlast;
    logic        trigger_tvalid;
    logic        trigger_tready;

    modport master (
        output set_stb, set_addr, set_data, trigger_tready,
        input  trigger_tdata, trigger_tlast, trigger_tvalid
    );

    modport slave (
        input  set_stb, set_addr, set_data, trigger_tready,
        output trigger_tdata, trigger_tlast, trigger_tvalid
    );
endinterface

// File: rtl/framer_trigger_sched.sv
// Per-sample trigger stream generator for periodic_framer.
// One beat per sample (tvalid always high); tlast flags trigger samples: the first
// after DELAY beats from start, then one every PERIOD beats, COUNT times (0 = forever).
module framer_trigger_sched #(
    parameter logic [7:0] SR_TRIG_PERIOD = 8'd5,
    parameter logic [7:0] SR_TRIG_DELAY  = 8'd6,
    parameter logic [7:0] SR_TRIG_COUNT  = 8'd7,
    parameter logic [7:0] SR_TRIG_CTRL   = 8'd8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          clear_i,
    input  logic                          ext_start_i,
    framer_trigger_sched_if.slave         bus,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_RUN} state_e;

    state_e      state_q, state_d;
    logic [15:0] period_q, delay_q, count_q;
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] trig_idx_q, trig_idx_d;
    logic        stop_pend_q, stop_pend_d;
    logic        done_q, done_d;

    logic        ctrl_wr, start_cmd, stop_cmd, beat, tlast_c;
    logic [15:0] period_eff, beat_inc;
    logic        unused_set_bits;

    // Upper settings bits carry nothing for this block.
    assign unused_set_bits = ^bus.set_data[31:16];

    // CTRL bits are write strobes; an ext_start coinciding with a settings start is one start.
    assign ctrl_wr   = bus.set_stb && (bus.set_addr == SR_TRIG_CTRL);
    assign start_cmd = (ctrl_wr && bus.set_data[0]) || ext_start_i;
    assign stop_cmd  = ctrl_wr && bus.set_data[1];
    assign beat      = bus.trigger_tready;   // tvalid is constant 1

    // Config registers: survive clear, only reset_n zeroes them.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            period_q <= '0;
            delay_q  <= '0;
            count_q  <= '0;
        end else if (bus.set_stb) begin
            if (bus.set_addr == SR_TRIG_PERIOD) period_q <= bus.set_data[15:0];
            if (bus.set_addr == SR_TRIG_DELAY)  delay_q  <= bus.set_data[15:0];
            if (bus.set_addr == SR_TRIG_COUNT)  count_q  <= bus.set_data[15:0];
        end
    end

    // Trigger compare: equality in DELAY, >= in RUN so a shrunk PERIOD fires on the next beat.
    always_comb begin
        period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
        beat_inc   = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
        case (state_q)
            ST_DELAY: tlast_c = (beat_cnt_q == delay_q);
            ST_RUN:   tlast_c = (beat_cnt_q >= period_eff);
            default:  tlast_c = 1'b0;
        endcase
    end

    // Next-state logic: sequencing, stop handling and completion.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        trig_idx_d  = trig_idx_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start_cmd && !stop_cmd) begin
                    state_d    = ST_DELAY;
                    beat_cnt_d = '0;
                    trig_idx_d = '0;
                end
            end
            default: begin
                if (stop_cmd) stop_pend_d = 1'b1;
                if (stop_pend_q && !tlast_c) begin
                    // Nothing committed on the wire: stop right away.
                    state_d     = ST_IDLE;
                    stop_pend_d = 1'b0;
                end else if (beat) begin
                    if (tlast_c) begin
                        state_d    = ST_RUN;
                        beat_cnt_d = 16'd1;
                        trig_idx_d = trig_idx_q + 16'd1;
                        if (stop_pend_q) begin
                            // Presented trigger has gone out; stopping is not completion.
                            state_d     = ST_IDLE;
                            stop_pend_d = 1'b0;
                        end else if (count_q != 16'd0 && trig_idx_q + 16'd1 == count_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end
        endcase
        if (clear_i) begin
            state_d     = ST_IDLE;
            beat_cnt_d  = '0;
            trig_idx_d  = '0;
            stop_pend_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            trig_idx_q  <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            trig_idx_q  <= trig_idx_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
        end
    end

    assign bus.trigger_tvalid = 1'b1;
    assign bus.trigger_tlast  = tlast_c;
    assign bus.trigger_tdata  = (state_q == ST_IDLE) ? 16'd0 : trig_idx_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign done_o             = done_q;

endmodule

// File: tb/tb_framer_trigger_sched.sv
// Directed bench for framer_trigger_sched: inputs driven and outputs sampled on the falling edge.
module tb_framer_trigger_sched;

    localparam logic [7:0] A_PER = 8'd5, A_DLY = 8'd6, A_CNT = 8'd7, A_CTL = 8'd8;

    logic clk, rst_n, clear, ext_start, busy, done;
    int   n_chk, n_fail;

    framer_trigger_sched_if bus();

    framer_trigger_sched dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .clear_i     (clear),
        .ext_start_i (ext_start),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic sr_wr(input logic [7:0] a, input logic [31:0] d);
        bus.set_stb  = 1'b1;
        bus.set_addr = a;
        bus.set_data = d;
        @(negedge clk);
        bus.set_stb  = 1'b0;
    endtask

    task automatic cfg(input logic [15:0] per, input logic [15:0] dly, input logic [15:0] cnt);
        sr_wr(A_PER, {16'd0, per});
        sr_wr(A_DLY, {16'd0, dly});
        sr_wr(A_CNT, {16'd0, cnt});
    endtask

    task automatic ext_go();
        ext_start = 1'b1;
        @(negedge clk);
        ext_start = 1'b0;
    endtask

    // Reference for PERIOD=4 DELAY=2 COUNT=3: triggers on beats 3, 7, 11.
    function automatic logic exp_tlast(input int bn);
        return (bn == 3 || bn == 7 || bn == 11);
    endfunction

    function automatic logic [15:0] exp_tdata(input int bn);
        if (bn <= 3) return 16'd0;
        if (bn <= 7) return 16'd1;
        return 16'd2;
    endfunction

    // Full PERIOD=4/DELAY=2/COUNT=3 run under a 16-cycle tready pattern.
    task automatic run_check(input string tag, input logic [15:0] rdy, input bit dup, input bit both);
        int bn;
        int cyc;
        bus.set_stb  = 1'b1;
        bus.set_addr = A_CTL;
        bus.set_data = 32'd1;
        ext_start    = both;
        @(negedge clk);
        bus.set_stb  = 1'b0;
        ext_start    = 1'b0;
        bn  = 1;
        cyc = 0;
        while (bn <= 11 && cyc < 200) begin
            bus.trigger_tready = rdy[cyc % 16];
            ext_start = dup && (cyc == 5);
            chk({tag, "_tlast"}, bus.trigger_tlast, exp_tlast(bn));
            chk({tag, "_tdata"}, bus.trigger_tdata, exp_tdata(bn));
            chk({tag, "_busy"},  busy, 1'b1);
            chk({tag, "_tvalid"}, bus.trigger_tvalid, 1'b1);
            if (bus.trigger_tready) bn++;
            @(negedge clk);
            cyc++;
        end
        ext_start = 1'b0;
        chk({tag, "_beats"}, bn, 12);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_tlast_idle"}, bus.trigger_tlast, 1'b0);
        bus.trigger_tready = 1'b1;
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bad_tlast;
        bit  saw_done;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        ext_start = 1'b0;
        bus.set_stb = 1'b0;
        bus.set_addr = '0;
        bus.set_data = '0;
        bus.trigger_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tvalid", bus.trigger_tvalid, 1'b1);
        chk("rst_tlast", bus.trigger_tlast, 1'b0);
        chk("rst_tdata", bus.trigger_tdata, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run, then stalled run with a redundant start mid-run and a double start.
        cfg(16'd4, 16'd2, 16'd3);
        run_check("t1", 16'hFFFF, 1'b0, 1'b0);
        run_check("t2", 16'b0110_1011_0011_1010, 1'b1, 1'b1);

        // Stop while a trigger beat is stalled: trigger still goes out, no done.
        cfg(16'd4, 16'd2, 16'd0);
        sr_wr(A_CTL, 32'd1);
        bus.trigger_tready = 1'b1;
        chk("t4_b1", bus.trigger_tlast, 1'b0);
        @(negedge clk);
        chk("t4_b2", bus.trigger_tlast, 1'b0);
        @(negedge clk);
        chk("t4_b3", bus.trigger_tlast, 1'b1);
        bus.trigger_tready = 1'b0;
        sr_wr(A_CTL, 32'd2);
        chk("t4_hold1", bus.trigger_tlast, 1'b1);
        chk("t4_busy1", busy, 1'b1);
        @(negedge clk);
        chk("t4_hold2", bus.trigger_tlast, 1'b1);
        chk("t4_tdata", bus.trigger_tdata, 16'd0);
        bus.trigger_tready = 1'b1;
        @(negedge clk);
        chk("t4_idle", busy, 1'b0);
        chk("t4_tlast0", bus.trigger_tlast, 1'b0);
        chk("t4_nodone", done, 1'b0);
        @(negedge clk);
        chk("t4_nodone2", done, 1'b0);

        // Start and stop in one write: stays idle.
        sr_wr(A_CTL, 32'd3);
        chk("t5_idle", busy, 1'b0);
        @(negedge clk);
        chk("t5_idle2", busy, 1'b0);
        chk("t5_tlast", bus.trigger_tlast, 1'b0);

        // Clear at beat 5, then a fresh run on the retained config.
        cfg(16'd4, 16'd2, 16'd3);
        sr_wr(A_CTL, 32'd1);
        for (int b = 1; b <= 4; b++) begin
            chk("t6_pre_tlast", bus.trigger_tlast, exp_tlast(b));
            @(negedge clk);
        end
        chk("t6_b5_tdata", bus.trigger_tdata, 16'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t6_clr_busy", busy, 1'b0);
        chk("t6_clr_tlast", bus.trigger_tlast, 1'b0);
        chk("t6_clr_tdata", bus.trigger_tdata, 16'd0);
        chk("t6_clr_done", done, 1'b0);
        run_check("t6r", 16'hFFFF, 1'b0, 1'b0);

        // Continuous, trigger every beat, tdata wraps past 0xFFFF.
        cfg(16'd1, 16'd0, 16'd0);
        ext_go();
        bad_tlast = 0;
        saw_done  = 1'b0;
        for (int bn = 1; bn <= 65537; bn++) begin
            if (bus.trigger_tlast !== 1'b1) bad_tlast++;
            if (done) saw_done = 1'b1;
            if (bn == 1 || bn == 2 || bn == 65536 || bn == 65537) begin
                logic [15:0] e;
                e = 16'(bn - 1);
                chk("t3_tdata", bus.trigger_tdata, e);
            end
            @(negedge clk);
        end
        chk("t3_all_tlast", bad_tlast, 0);
        chk("t3_nodone", saw_done, 1'b0);
        chk("t3_busy", busy, 1'b1);
        sr_wr(A_CTL, 32'd2);
        @(negedge clk);
        chk("t3_stopped", busy, 1'b0);
        chk("t3_stop_nodone", done, 1'b0);

        // Async reset mid-run returns everything, config included, to zero.
        cfg(16'd4, 16'd2, 16'd3);
        ext_go();
        @(negedge clk);
        @(negedge clk);
        chk("t7_pre_tlast", bus.trigger_tlast, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_rst_tlast", bus.trigger_tlast, 1'b0);
        chk("t7_rst_tdata", bus.trigger_tdata, 16'd0);
        chk("t7_rst_tvalid", bus.trigger_tvalid, 1'b1);
        chk("t7_rst_busy", busy, 1'b0);
        chk("t7_rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Zeroed config: DELAY=0, PERIOD treated as 1, continuous.
        ext_go();
        chk("t7_z_b1_tlast", bus.trigger_tlast, 1'b1);
        chk("t7_z_b1_tdata", bus.trigger_tdata, 16'd0);
        @(negedge clk);
        chk("t7_z_b2_tlast", bus.trigger_tlast, 1'b1);
        chk("t7_z_b2_tdata", bus.trigger_tdata, 16'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t7_z_clear", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
